// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int WORD_W          = 32;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        ISSUE = 2'd2,
        EXEC  = 2'd3
    } state_e;

    // Dummy data pattern for the PREP phase. It must differ from the value
    // currently on the RAM data port (so the RAM sees a change now) and from
    // the real write data (so the RAM sees a second change at ISSUE).
    function automatic logic [WORD_W-1:0] prep_pattern(
        input logic [WORD_W-1:0] wdata,
        input logic [WORD_W-1:0] cur
    );
        logic [WORD_W-1:0] inv;
        inv = ~wdata;
        if (inv != cur) begin
            return inv;
        end
        return cur ^ {{(WORD_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two request ports plus busy.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [WORD_W-1:0] addr0;
    logic [WORD_W-1:0] addr1;
    logic [WORD_W-1:0] wdata0;
    logic [WORD_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [WORD_W-1:0] rdata0;
    logic [WORD_W-1:0] rdata1;
    logic              busy;

    // Requesters drive requests and consume completions.
    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1, busy
    );

    // The arbiter consumes requests and produces completions.
    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata0, rdata1, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that was not granted last.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Pick the winning port from the current requests and the previous winner.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and sequencer for the change-triggered RAM.
// Every transaction drives a dummy PREP pattern followed by the real pattern,
// so the RAM always sees two input changes, then waits for its response pulse.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_write,
    input  logic              mem_response,
    input  logic [WORD_W-1:0] mem_out
);

    localparam int CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic              port_q;
    logic              wr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [CNT_W-1:0]  wait_q;
    logic              last_grant_q;
    logic [WORD_W-1:0] mem_address_q;
    logic [WORD_W-1:0] mem_data_q;
    logic              mem_write_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              err0_q;
    logic              err1_q;
    logic [WORD_W-1:0] rdata0_q;
    logic [WORD_W-1:0] rdata1_q;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_wr_d;
    logic [WORD_W-1:0] sel_addr_d;
    logic [WORD_W-1:0] sel_wdata_d;
    logic [WORD_W-1:0] prep_d;
    logic              advance_d;
    logic              timed_out;

    rr_arb2 u_rr (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_grant  (last_grant_q),
        .grant_valid (gnt_valid),
        .grant_id    (gnt_id)
    );

    // Fields of the port that would be granted this cycle, and its prep pattern.
    always_comb begin
        sel_wr_d    = gnt_id ? bus.wr1    : bus.wr0;
        sel_addr_d  = gnt_id ? bus.addr1  : bus.addr0;
        sel_wdata_d = gnt_id ? bus.wdata1 : bus.wdata0;
        prep_d      = prep_pattern(sel_wdata_d, mem_data_q);
    end

    // Exit condition of each wait state: PREP and ISSUE wait for the response
    // pulse to rise, EXEC waits for it to fall (the RAM has executed).
    always_comb begin
        advance_d = 1'b0;
        case (state_q)
            PREP:    advance_d = mem_response;
            ISSUE:   advance_d = mem_response;
            EXEC:    advance_d = ~mem_response;
            default: advance_d = 1'b0;
        endcase
    end

    assign timed_out = (wait_q == CNT_W'(TIMEOUT));

    // Sequencer FSM with its wait counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            port_q        <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            wait_q        <= '0;
            last_grant_q  <= 1'b1;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_write_q   <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            // ack/err are single-cycle pulses
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;

            if (state_q == IDLE) begin
                if (gnt_valid) begin
                    port_q        <= gnt_id;
                    last_grant_q  <= gnt_id;
                    wr_q          <= sel_wr_d;
                    wdata_q       <= sel_wdata_d;
                    mem_address_q <= sel_addr_d;
                    mem_data_q    <= prep_d;
                    mem_write_q   <= 1'b0;
                    wait_q        <= '0;
                    state_q       <= PREP;
                end
            end else if (advance_d) begin
                wait_q <= '0;
                case (state_q)
                    PREP: begin
                        mem_data_q  <= wdata_q;
                        mem_write_q <= wr_q;
                        state_q     <= ISSUE;
                    end
                    ISSUE: begin
                        state_q <= EXEC;
                    end
                    default: begin
                        if (!wr_q) begin
                            if (port_q) rdata1_q <= mem_out;
                            else        rdata0_q <= mem_out;
                        end
                        if (port_q) ack1_q <= 1'b1;
                        else        ack0_q <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end else if (timed_out) begin
                // Abort: report the error and leave rdata untouched.
                if (port_q) begin
                    ack1_q <= 1'b1;
                    err1_q <= 1'b1;
                end else begin
                    ack0_q <= 1'b1;
                    err0_q <= 1'b1;
                end
                wait_q  <= '0;
                state_q <= IDLE;
            end else begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_write   = mem_write_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port change-triggered `ram`. It accepts word read/write requests from two requesters, such as the cache and a refill/DMA engine. It converts each request into the RAM's change-detect handshake, and returns read data with a one-cycle acknowledge. All `mem_*` outputs are registered and connect directly to the `ram` ports.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles spent in any wait state before the transaction is aborted with an error.
- `clk`  in  1  clock; everything updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  request; must be held with its fields stable until the matching ack.
- `wr0` / `wr1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  32  word address.
- `wdata0` / `wdata1`  in  32  write data.
- `ack0` / `ack1`  out  1  one-cycle pulse: transaction complete.
- `err0` / `err1`  out  1  valid with ack; 1 = timed out.
- `rdata0` / `rdata1`  out  32  read data; valid with ack, held until the next ack on that port.
- `busy`  out  1  high in any state except IDLE.
- `mem_address`, `mem_data`  out  32  drive the `ram` `address` and `data` ports.
- `mem_write`  out  1  drives `ram` `write`.
- `mem_response`  in  1  from `ram` `response`.
- `mem_out`  in  32  from `ram` `out`.

## Operation
- States: IDLE, PREP, ISSUE, EXEC.
- Reset value of every output is 0; `last_grant` resets to 1, so port 0 wins the first tie.
- **IDLE**
  - No request: stay in IDLE; `mem_*` hold their values.
  - One request: grant that port.
  - Both requesting: grant the port not equal to `last_grant`.
  - On grant: latch the port id and its fields, update `last_grant`, go to PREP.
  - PREP drives `mem_address` = addr, `mem_write` = 0, and `mem_data` = P.
- **Prep pattern P**
  - P = ~wdata if ~wdata != current `mem_data`, else P = `mem_data` ^ 1.
  - P therefore differs from both the previously driven pattern and the real pattern.
  - Result: every transaction produces two input changes at the RAM, even for back-to-back identical requests.
  - The PREP operation is a harmless dummy read.
- **PREP**
  - Wait until `mem_response` = 1.
  - Then drive the real pattern (addr, wdata, wr) and go to ISSUE.
- **ISSUE**
  - Wait until `mem_response` = 1, then go to EXEC.
- **EXEC**
  - Wait until `mem_response` = 0.
  - Then capture `mem_out` into `rdata` of the granted port (reads only; writes leave `rdata` unchanged).
  - Pulse `ack` with `err` = 0 and return to IDLE.
- **Timeout**
  - A 4-bit-or-wider wait counter clears on every state entry.
  - When it reaches `TIMEOUT` in PREP, ISSUE or EXEC: pulse `ack` with `err` = 1, leave `rdata` unchanged, go to IDLE.
- **Request dropped mid-transaction:** ignored; the transaction completes and still acks.
- **Asynchronous reset mid-transaction:** go to IDLE immediately and zero all outputs. No ack is issued. The RAM may finish the pending operation.

## Timing
- Nominal sequence with `ram`, where E0 is the edge at which IDLE accepts a request:
  - E1: RAM sees the prep pattern.
  - E2: arbiter enters ISSUE.
  - E3: RAM sees the real pattern.
  - E4: RAM executes; arbiter enters EXEC.
  - E5: `ack` and `rdata` are registered.
- The ack is visible during the cycle after E5, i.e. five cycles of latency.
- IDLE is active in the ack cycle, so the next grant occurs at E6. Sustained throughput is one transaction per 6 cycles.
- Under continuous contention the two ports alternate strictly.

## Structure
- A shared package `ram_arb_pkg` holds:
  - the state enum (IDLE, PREP, ISSUE, EXEC);
  - `WORD_W` = 32;
  - the default `TIMEOUT`.
- Sub-module `rr_arb2`: a combinational 2-way round-robin pick from the two `req` lines and `last_grant`.
- The FSM, timeout counter and output registers live in `ram_arbiter`.

## Test plan
- **Single read:** write 0xDEADBEEF to address 5 via port 0, then read address 5 via port 1.
  - Required: `ack1` five cycles after acceptance; `rdata1` = 0xDEADBEEF; `err1` = 0.
- **Identical back-to-back reads:** port 0 reads address 5 twice in a row.
  - Required: both reads ack; both return 0xDEADBEEF.
- **Simultaneous requests:** both ports request at reset exit.
  - Required: port 0 is served first, then port 1; the next tie goes to port 0.
  - Repeat for 10 transactions; grants must strictly alternate.
- **Complement corner:** write 0x00000000 to address 7, then write 0xFFFFFFFF to address 7, then read address 7.
  - Required: the read returns 0xFFFFFFFF.
- **Timeout:** tie `mem_response` to 0.
  - Required: `ack0` with `err0` = 1 after `TIMEOUT` cycles in PREP; `rdata0` unchanged; `busy` low afterwards.
- **Reset during ISSUE:** assert `rst_n` low while the arbiter is in ISSUE.
  - Required: all outputs read 0 immediately with no ack.
  - After release, a new port 1 write followed by a read of the same address returns the written value.
